// File: rtl/seg7_scan_mux_if.sv
// Display bus between the stopwatch/timer logic and the seven-segment scan driver.
// Latency: none (wires only).
// Backpressure: none; the driver samples levels, and the display consumes the outputs continuously.
interface seg7_scan_mux_if;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic [3:0]  blink_mask;
    logic        blink_en;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    // Timer/stopwatch side: supplies digit data and display modes.
    modport master (
        output digits, dp_mask, blink_mask, blink_en, blank_lz,
        input  an, seg, dp
    );

    // Scan driver side.
    modport slave (
        input  digits, dp_mask, blink_mask, blink_en, blank_lz,
        output an, seg, dp
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// Four-digit multiplexed seven-segment driver, stepped by the divided scan_clk.
// Latency: a scan_clk rise first sampled at clk edge N updates the outputs at edge N+3.
// Backpressure: none; the outputs hold between refresh ticks and freeze if scan_clk stops toggling.
module seg7_scan_mux #(
    parameter int BLINK_EDGES = 256
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           scan_clk,
    seg7_scan_mux_if.slave disp
);

    localparam int CNT_W = $clog2(BLINK_EDGES);

    // Synchronizer, edge-detect delay and registered tick.
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sync3_q, sync3_d;
    logic tick_q, tick_d;

    // Scan state.
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      snap_q, snap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    // Registered display outputs.
    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;

    // Working values for the slot being loaded.
    logic [1:0]  nxt_idx;
    logic [15:0] frame;
    logic [3:0]  digit;
    logic        lz3, lz2, lz1, blank;

    // Map a BCD nibble to active-low segments {g..a}; non-BCD values show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // Bring scan_clk into the clk domain and flag each rising edge for one cycle.
    always_comb begin
        sync1_d = scan_clk;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        tick_d  = sync2_q & ~sync3_q;
    end

    // Advance the slot, snapshot at frame start, run the blink timer and build the outputs.
    always_comb begin
        idx_d   = idx_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        an_d    = an_q;
        seg_d   = seg_q;
        dp_d    = dp_q;

        nxt_idx = idx_q + 2'd1;
        // Slot 0 of a new frame shows the digits captured on this same tick.
        frame   = (idx_q == 2'd3) ? disp.digits : snap_q;
        digit   = frame[{nxt_idx, 2'b00} +: 4];

        // A leading zero blanks only if every digit to its left is also blank.
        lz3 = (frame[15:12] == 4'd0);
        lz2 = lz3 && (frame[11:8] == 4'd0);
        lz1 = lz2 && (frame[7:4] == 4'd0);
        case (nxt_idx)
            2'd3:    blank = disp.blank_lz && lz3;
            2'd2:    blank = disp.blank_lz && lz2;
            2'd1:    blank = disp.blank_lz && lz1;
            default: blank = 1'b0;
        endcase

        if (tick_q) begin
            idx_d = nxt_idx;
            if (idx_q == 2'd3) begin
                snap_d = disp.digits;
            end

            // The blink timer runs even with blinking disabled, so the phase stays steady.
            if (cnt_q == CNT_W'(BLINK_EDGES - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            seg_d = blank ? 7'h7F : seg_decode(digit);
            dp_d  = ~disp.dp_mask[nxt_idx];
            an_d  = ~(4'b0001 << nxt_idx);
            // Use the phase in effect before this tick's toggle, which keeps each blink window whole.
            if (disp.blink_en && phase_q && disp.blink_mask[nxt_idx]) begin
                an_d = 4'b1111;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            tick_q  <= 1'b0;
            idx_q   <= 2'd0;
            snap_q  <= 16'h0000;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            an_q    <= 4'b1111;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign disp.an  = an_q;
    assign disp.seg = seg_q;
    assign disp.dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux: reset, scan order/latency, blanking, snapshot, dp, blink.
// Latency: each refresh edge is checked one clk edge before and at the expected update edge.
// Backpressure: none; the bench drives scan_clk and samples outputs #1 after the clk edge.
module tb_seg7_scan_mux;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic scan_clk = 1'b0;

    int total = 0;
    int bad   = 0;

    // Expected output values, maintained by the bench, for the hold check.
    logic [3:0] last_an  = 4'b1111;
    logic [6:0] last_seg = 7'h7F;
    logic       last_dp  = 1'b1;

    seg7_scan_mux_if dif ();

    seg7_scan_mux #(.BLINK_EDGES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .scan_clk (scan_clk),
        .disp     (dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        chk({tag, "_an"},  {12'h0, dif.an},  {12'h0, ea});
        chk({tag, "_seg"}, {9'h0, dif.seg},  {9'h0, es});
        chk({tag, "_dp"},  {15'h0, dif.dp},  {15'h0, ed});
    endtask

    // Hold reset for several cycles with scan_clk toggling, check the outputs, then release.
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset    = 1'b1;
        scan_clk = 1'b1;
        @(negedge clk);
        chk_out({tag, "0"}, 4'b1111, 7'h7F, 1'b1);
        scan_clk = 1'b0;
        @(negedge clk);
        chk_out({tag, "1"}, 4'b1111, 7'h7F, 1'b1);
        scan_clk = 1'b1;
        @(negedge clk);
        scan_clk = 1'b0;
        repeat (3) @(negedge clk);
        reset    = 1'b0;
        last_an  = 4'b1111;
        last_seg = 7'h7F;
        last_dp  = 1'b1;
    endtask

    // One scan_clk rising edge: outputs hold through edge N+2, then update at edge N+3.
    task automatic tick_chk(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        @(negedge clk);
        scan_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_out({tag, "_hold"}, last_an, last_seg, last_dp);
        @(posedge clk);
        #1;
        chk_out(tag, ea, es, ed);
        last_an  = ea;
        last_seg = es;
        last_dp  = ed;
        scan_clk = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    logic [3:0] blink_an [16] = '{
        4'b1101, 4'b1011, 4'b0111, 4'b1110,
        4'b1101, 4'b1011, 4'b0111, 4'b1111,
        4'b1101, 4'b1011, 4'b0111, 4'b1110,
        4'b1101, 4'b1011, 4'b0111, 4'b1111
    };

    initial begin
        dif.digits     = 16'h1234;
        dif.dp_mask    = 4'b0000;
        dif.blink_mask = 4'b0000;
        dif.blink_en   = 1'b0;
        dif.blank_lz   = 1'b0;

        do_reset("rst");

        // Scan order and latency; the first frame still shows the cleared snapshot.
        tick_chk("scan1", 4'b1101, 7'h40, 1'b1);
        tick_chk("scan2", 4'b1011, 7'h40, 1'b1);
        tick_chk("scan3", 4'b0111, 7'h40, 1'b1);
        tick_chk("scan4", 4'b1110, 7'h19, 1'b1);
        tick_chk("scan5", 4'b1101, 7'h30, 1'b1);
        tick_chk("scan6", 4'b1011, 7'h24, 1'b1);
        tick_chk("scan7", 4'b0111, 7'h79, 1'b1);
        tick_chk("scan8", 4'b1110, 7'h19, 1'b1);

        // Leading-zero blanking; 1234 has no leading zeros, then 0007 blanks three slots.
        dif.blank_lz = 1'b1;
        dif.digits   = 16'h0007;
        tick_chk("lz1",  4'b1101, 7'h30, 1'b1);
        tick_chk("lz2",  4'b1011, 7'h24, 1'b1);
        tick_chk("lz3",  4'b0111, 7'h79, 1'b1);
        tick_chk("lz4",  4'b1110, 7'h78, 1'b1);
        tick_chk("lz5",  4'b1101, 7'h7F, 1'b1);
        tick_chk("lz6",  4'b1011, 7'h7F, 1'b1);
        tick_chk("lz7",  4'b0111, 7'h7F, 1'b1);
        dif.digits = 16'h0000;
        tick_chk("lz8",  4'b1110, 7'h40, 1'b1);

        // Snapshot: a mid-frame change stays hidden until the next frame.
        dif.blank_lz = 1'b0;
        dif.digits   = 16'h1111;
        tick_chk("snap1", 4'b1101, 7'h40, 1'b1);
        tick_chk("snap2", 4'b1011, 7'h40, 1'b1);
        tick_chk("snap3", 4'b0111, 7'h40, 1'b1);
        tick_chk("snap4", 4'b1110, 7'h79, 1'b1);
        tick_chk("snap5", 4'b1101, 7'h79, 1'b1);
        dif.digits = 16'h9999;
        tick_chk("snap6", 4'b1011, 7'h79, 1'b1);
        tick_chk("snap7", 4'b0111, 7'h79, 1'b1);
        tick_chk("snap8", 4'b1110, 7'h10, 1'b1);
        tick_chk("snap9", 4'b1101, 7'h10, 1'b1);
        tick_chk("snapa", 4'b1011, 7'h10, 1'b1);
        tick_chk("snapb", 4'b0111, 7'h10, 1'b1);

        // Invalid BCD shows a dash; the decimal point follows dp_mask live.
        dif.digits  = 16'hA000;
        dif.dp_mask = 4'b0100;
        tick_chk("inv0", 4'b1110, 7'h40, 1'b1);
        tick_chk("inv1", 4'b1101, 7'h40, 1'b1);
        tick_chk("inv2", 4'b1011, 7'h40, 1'b0);
        tick_chk("inv3", 4'b0111, 7'h3F, 1'b1);

        // Mid-frame reset, then blinking slot 0 with BLINK_EDGES=4.
        dif.digits     = 16'h0000;
        dif.dp_mask    = 4'b0000;
        dif.blink_mask = 4'b0001;
        dif.blink_en   = 1'b1;
        do_reset("rst_mid");
        for (int k = 0; k < 16; k++) begin
            tick_chk($sformatf("blink%0d", k + 1), blink_an[k], 7'h40, 1'b1);
        end

        // Blink disabled: slot 0 shows even during the phase-1 window.
        dif.blink_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick_chk($sformatf("noblink%0d", k + 17), blink_an[k % 4 == 3 ? 3 : k % 4], 7'h40, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
